// File: rtl/hid_mem_arbiter.sv
// Arbitrates one HID memory port among NREQ request/grant masters and routes read responses back.
// Define HID_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
module hid_mem_arbiter #(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk_i,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_i,
  input  logic [NREQ-1:0]                  we_i,
  input  logic [NREQ*ADDR_WIDTH-1:0]       addr_i,
  input  logic [NREQ*DATA_WIDTH/8-1:0]     be_i,
  input  logic [NREQ*DATA_WIDTH-1:0]       wdata_i,
  output logic [NREQ-1:0]                  gnt_o,
  output logic [NREQ-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             hid_en,
  output logic [DATA_WIDTH/8-1:0]          hid_we,
  output logic [ADDR_WIDTH-1:0]            hid_addr,
  output logic [DATA_WIDTH-1:0]            hid_wrdata,
  input  logic [DATA_WIDTH-1:0]            hid_rddata
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             any_req;
  logic [IDX_W-1:0] win_idx;

  assign any_req = |req_i;

`ifdef HID_ARB_RR_EN
  logic [IDX_W-1:0] last_q, last_d;
  logic             found;
  int               cand;

  // Search starts just after the previous winner, so index 0 leads when last_q wraps at NREQ-1.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last_q) + off) % NREQ;
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    last_d = any_req ? win_idx : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      last_q <= IDX_W'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    gnt_o      = '0;
    hid_en     = any_req;
    hid_we     = '0;
    hid_addr   = '0;
    hid_wrdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = any_req && (win_idx == IDX_W'(i));
    end
    if (any_req) begin
      hid_addr   = addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      hid_wrdata = wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      if (we_i[win_idx]) begin
        hid_we = be_i[int'(win_idx)*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  // Every grant, read or write, travels down the pipe so responses come back in issue order.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]      own_q [RD_LATENCY];
  logic [IDX_W-1:0]      own_d [RD_LATENCY];

  always_comb begin
    vld_d    = '0;
    own_d    = '{default: '0};
    vld_d[0] = any_req;
    own_d[0] = win_idx;
    for (int s = 1; s < RD_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      own_d[s] = own_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (vld_q[RD_LATENCY-1] && !rst) begin
      for (int i = 0; i < NREQ; i++) begin
        rvalid_o[i] = (own_q[RD_LATENCY-1] == IDX_W'(i));
      end
      rdata_o = hid_rddata;
    end
  end

endmodule

// File: tb/tb_hid_mem_arbiter.sv
// Directed bench for hid_mem_arbiter: one instance at read latency 1, one at latency 3, each with a memory model.
// Arbitration checks follow HID_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module tb_hid_mem_arbiter;

  logic clk;
  logic rst;

  logic [2:0]   req1, we1, gnt1, rvalid1;
  logic [53:0]  addr1;
  logic [23:0]  be1;
  logic [191:0] wdata1;
  logic [63:0]  rdata1, hid_wrdata1, hid_rddata1;
  logic         hid_en1;
  logic [7:0]   hid_we1;
  logic [17:0]  hid_addr1;

  logic [2:0]   req3, we3, gnt3, rvalid3;
  logic [53:0]  addr3;
  logic [23:0]  be3;
  logic [191:0] wdata3;
  logic [63:0]  rdata3, hid_wrdata3, hid_rddata3;
  logic         hid_en3;
  logic [7:0]   hid_we3;
  logic [17:0]  hid_addr3;

  int compared;
  int mismatched;
  int g0, g1, g2;

  hid_mem_arbiter #(.NREQ(3), .ADDR_WIDTH(18), .DATA_WIDTH(64), .RD_LATENCY(1)) dut1 (
    .clk_i(clk), .rst(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .be_i(be1),
    .wdata_i(wdata1), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
    .hid_en(hid_en1), .hid_we(hid_we1), .hid_addr(hid_addr1),
    .hid_wrdata(hid_wrdata1), .hid_rddata(hid_rddata1)
  );

  hid_mem_arbiter #(.NREQ(3), .ADDR_WIDTH(18), .DATA_WIDTH(64), .RD_LATENCY(3)) dut3 (
    .clk_i(clk), .rst(rst), .req_i(req3), .we_i(we3), .addr_i(addr3), .be_i(be3),
    .wdata_i(wdata3), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
    .hid_en(hid_en3), .hid_we(hid_we3), .hid_addr(hid_addr3),
    .hid_wrdata(hid_wrdata3), .hid_rddata(hid_rddata3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: unwritten words read as 64'h1111_0000_2222_0000 | addr.
  function automatic logic [63:0] initWord(input logic [7:0] a);
    return 64'h1111_0000_2222_0000 | {56'd0, a};
  endfunction

  function automatic logic [63:0] mergeBytes(input logic [63:0] old, input logic [63:0] nw,
                                             input logic [7:0] be);
    logic [63:0] m;
    m = old;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) m[b*8 +: 8] = nw[b*8 +: 8];
    end
    return m;
  endfunction

  logic [63:0] mem1 [256];
  logic [63:0] mem3 [256];
  bit          wrv1 [256];
  bit          wrv3 [256];
  logic [63:0] cur1, cur3;
  logic [63:0] pipe1;
  logic [63:0] pipe3 [3];

  assign cur1 = wrv1[hid_addr1[7:0]] ? mem1[hid_addr1[7:0]] : initWord(hid_addr1[7:0]);
  assign cur3 = wrv3[hid_addr3[7:0]] ? mem3[hid_addr3[7:0]] : initWord(hid_addr3[7:0]);
  assign hid_rddata1 = pipe1;
  assign hid_rddata3 = pipe3[2];

  always @(posedge clk) begin
    if (hid_en1 && hid_we1 != 8'h00) begin
      mem1[hid_addr1[7:0]] <= mergeBytes(cur1, hid_wrdata1, hid_we1);
      wrv1[hid_addr1[7:0]] <= 1'b1;
    end
    pipe1 <= hid_en1 ? cur1 : 64'd0;
  end

  always @(posedge clk) begin
    if (hid_en3 && hid_we3 != 8'h00) begin
      mem3[hid_addr3[7:0]] <= mergeBytes(cur3, hid_wrdata3, hid_we3);
      wrv3[hid_addr3[7:0]] <= 1'b1;
    end
    pipe3[0] <= hid_en3 ? cur3 : 64'd0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  task automatic applyStimulus(input int inst, input int k, input logic r, input logic w,
                               input logic [17:0] a, input logic [7:0] b, input logic [63:0] d);
    if (inst == 1) begin
      req1[k] = r; we1[k] = w; addr1[k*18 +: 18] = a; be1[k*8 +: 8] = b; wdata1[k*64 +: 64] = d;
    end else begin
      req3[k] = r; we3[k] = w; addr3[k*18 +: 18] = a; be3[k*8 +: 8] = b; wdata3[k*64 +: 64] = d;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    compared = 0; mismatched = 0; g0 = 0; g1 = 0; g2 = 0;
    req1 = '0; we1 = '0; addr1 = '0; be1 = '0; wdata1 = '0;
    req3 = '0; we3 = '0; addr3 = '0; be3 = '0; wdata3 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_rvalid1", {61'd0, rvalid1}, 64'd0);
    checkOutput("reset_rdata1", rdata1, 64'd0);
    checkOutput("reset_gnt1", {61'd0, gnt1}, 64'd0);
    checkOutput("reset_hid_en1", {63'd0, hid_en1}, 64'd0);
    checkOutput("reset_rvalid3", {61'd0, rvalid3}, 64'd0);
    checkOutput("reset_rdata3", rdata3, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] two reads from masters 0 and 2, latency 1");
    applyStimulus(1, 0, 1'b1, 1'b0, 18'h10, 8'hFF, 64'd0);
    applyStimulus(1, 2, 1'b1, 1'b0, 18'h20, 8'hFF, 64'd0);
    #1;
    checkOutput("rd_gnt_m0", {61'd0, gnt1}, 64'b001);
    checkOutput("rd_addr_m0", {46'd0, hid_addr1}, 64'h10);
    checkOutput("rd_hid_we_m0", {56'd0, hid_we1}, 64'h0);
    checkOutput("rd_rvalid_idle", {61'd0, rvalid1}, 64'd0);
    @(negedge clk);
    applyStimulus(1, 0, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    #1;
    checkOutput("rd_gnt_m2", {61'd0, gnt1}, 64'b100);
    checkOutput("rd_addr_m2", {46'd0, hid_addr1}, 64'h20);
    checkOutput("rd_rvalid_m0", {61'd0, rvalid1}, 64'b001);
    checkOutput("rd_rdata_m0", rdata1, 64'h1111_0000_2222_0010);
    @(negedge clk);
    applyStimulus(1, 2, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    #1;
    checkOutput("rd_gnt_none", {61'd0, gnt1}, 64'd0);
    checkOutput("rd_hid_en_none", {63'd0, hid_en1}, 64'd0);
    checkOutput("rd_rvalid_m2", {61'd0, rvalid1}, 64'b100);
    checkOutput("rd_rdata_m2", rdata1, 64'h1111_0000_2222_0020);

    $display("[TB] master 1 partial write then read back");
    @(negedge clk);
    applyStimulus(1, 1, 1'b1, 1'b1, 18'h3, 8'h0F, 64'hDEADBEEF_01234567);
    #1;
    checkOutput("wr_rvalid_idle", {61'd0, rvalid1}, 64'd0);
    checkOutput("wr_gnt", {61'd0, gnt1}, 64'b010);
    checkOutput("wr_hid_we", {56'd0, hid_we1}, 64'h0F);
    checkOutput("wr_hid_addr", {46'd0, hid_addr1}, 64'h3);
    checkOutput("wr_hid_wrdata", hid_wrdata1, 64'hDEADBEEF_01234567);
    @(negedge clk);
    applyStimulus(1, 1, 1'b1, 1'b0, 18'h3, 8'hFF, 64'd0);
    #1;
    checkOutput("rb_gnt", {61'd0, gnt1}, 64'b010);
    checkOutput("rb_hid_we", {56'd0, hid_we1}, 64'h00);
    checkOutput("wr_rvalid", {61'd0, rvalid1}, 64'b010);
    @(negedge clk);
    applyStimulus(1, 1, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    #1;
    checkOutput("rb_rvalid", {61'd0, rvalid1}, 64'b010);
    checkOutput("rb_rdata", rdata1, 64'h1111_0000_0123_4567);
    @(negedge clk);
    #1;
    checkOutput("rb_rvalid_done", {61'd0, rvalid1}, 64'd0);

`ifdef HID_ARB_RR_EN
    $display("[TB] round-robin, all masters requesting for 30 cycles");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1, k, 1'b1, 1'b0, 18'h80 + 18'(k), 8'hFF, 64'd0);
    for (int i = 0; i < 30; i++) begin
      #1;
      checkOutput("rr_gnt", {61'd0, gnt1}, 64'd1 << (i % 3));
      checkOutput("rr_hid_en", {63'd0, hid_en1}, 64'd1);
      if (i > 0) checkOutput("rr_rvalid", {61'd0, rvalid1}, 64'd1 << ((i - 1) % 3));
      if (gnt1[0]) g0++;
      if (gnt1[1]) g1++;
      if (gnt1[2]) g2++;
      @(negedge clk);
    end
    req1 = '0;
    #1;
    checkOutput("rr_rvalid_last", {61'd0, rvalid1}, 64'b100);
    checkOutput("rr_count_m0", 64'(g0), 64'd10);
    checkOutput("rr_count_m1", 64'(g1), 64'd10);
    checkOutput("rr_count_m2", 64'(g2), 64'd10);
`else
    $display("[TB] fixed priority, masters 0 and 1 requesting");
    @(negedge clk);
    applyStimulus(1, 0, 1'b1, 1'b0, 18'h90, 8'hFF, 64'd0);
    applyStimulus(1, 1, 1'b1, 1'b0, 18'h91, 8'hFF, 64'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("fp_gnt_m0", {61'd0, gnt1}, 64'b001);
      @(negedge clk);
    end
    applyStimulus(1, 0, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    #1;
    checkOutput("fp_gnt_m1", {61'd0, gnt1}, 64'b010);
    @(negedge clk);
    req1 = '0;
`endif

    $display("[TB] latency 3, reads from masters 0,1,2,0 back to back");
    @(negedge clk);
    applyStimulus(3, 0, 1'b1, 1'b0, 18'h40, 8'hFF, 64'd0);
    #1;
    checkOutput("l3_gnt_c0", {61'd0, gnt3}, 64'b001);
    checkOutput("l3_rvalid_c0", {61'd0, rvalid3}, 64'd0);
    @(negedge clk);
    applyStimulus(3, 0, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    applyStimulus(3, 1, 1'b1, 1'b0, 18'h41, 8'hFF, 64'd0);
    #1;
    checkOutput("l3_gnt_c1", {61'd0, gnt3}, 64'b010);
    checkOutput("l3_rvalid_c1", {61'd0, rvalid3}, 64'd0);
    @(negedge clk);
    applyStimulus(3, 1, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    applyStimulus(3, 2, 1'b1, 1'b0, 18'h42, 8'hFF, 64'd0);
    #1;
    checkOutput("l3_gnt_c2", {61'd0, gnt3}, 64'b100);
    checkOutput("l3_rvalid_c2", {61'd0, rvalid3}, 64'd0);
    @(negedge clk);
    applyStimulus(3, 2, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    applyStimulus(3, 0, 1'b1, 1'b0, 18'h43, 8'hFF, 64'd0);
    #1;
    checkOutput("l3_gnt_c3", {61'd0, gnt3}, 64'b001);
    checkOutput("l3_rvalid_c3", {61'd0, rvalid3}, 64'b001);
    checkOutput("l3_rdata_c3", rdata3, 64'h1111_0000_2222_0040);
    @(negedge clk);
    applyStimulus(3, 0, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    #1;
    checkOutput("l3_rvalid_c4", {61'd0, rvalid3}, 64'b010);
    checkOutput("l3_rdata_c4", rdata3, 64'h1111_0000_2222_0041);
    @(negedge clk);
    #1;
    checkOutput("l3_rvalid_c5", {61'd0, rvalid3}, 64'b100);
    checkOutput("l3_rdata_c5", rdata3, 64'h1111_0000_2222_0042);
    @(negedge clk);
    #1;
    checkOutput("l3_rvalid_c6", {61'd0, rvalid3}, 64'b001);
    checkOutput("l3_rdata_c6", rdata3, 64'h1111_0000_2222_0043);
    @(negedge clk);
    #1;
    checkOutput("l3_rvalid_c7", {61'd0, rvalid3}, 64'd0);

    $display("[TB] reset while two reads are in flight");
    @(negedge clk);
    applyStimulus(3, 0, 1'b1, 1'b0, 18'h50, 8'hFF, 64'd0);
    #1;
    checkOutput("mr_gnt_d0", {61'd0, gnt3}, 64'b001);
    @(negedge clk);
    applyStimulus(3, 0, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    applyStimulus(3, 1, 1'b1, 1'b0, 18'h51, 8'hFF, 64'd0);
    #1;
    checkOutput("mr_gnt_d1", {61'd0, gnt3}, 64'b010);
    @(negedge clk);
    applyStimulus(3, 1, 1'b0, 1'b0, 18'h0, 8'h0, 64'd0);
    applyStimulus(3, 2, 1'b1, 1'b0, 18'h52, 8'hFF, 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("mr_gnt_in_reset", {61'd0, gnt3}, 64'b100);
    checkOutput("mr_hid_en_in_reset", {63'd0, hid_en3}, 64'd1);
    checkOutput("mr_rvalid_d2", {61'd0, rvalid3}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3, 0, 1'b1, 1'b0, 18'h60, 8'hFF, 64'd0);
    applyStimulus(3, 1, 1'b1, 1'b0, 18'h61, 8'hFF, 64'd0);
    applyStimulus(3, 2, 1'b1, 1'b0, 18'h62, 8'hFF, 64'd0);
    #1;
    checkOutput("mr_gnt_after_reset", {61'd0, gnt3}, 64'b001);
    checkOutput("mr_rvalid_d3", {61'd0, rvalid3}, 64'd0);
    @(negedge clk);
    req3 = '0;
    #1;
    checkOutput("mr_rvalid_d4", {61'd0, rvalid3}, 64'd0);
    @(negedge clk);
    #1;
    checkOutput("mr_rvalid_d5", {61'd0, rvalid3}, 64'd0);
    @(negedge clk);
    #1;
    checkOutput("mr_rvalid_d6", {61'd0, rvalid3}, 64'b001);
    checkOutput("mr_rdata_d6", rdata3, 64'h1111_0000_2222_0060);
    @(negedge clk);
    #1;
    checkOutput("mr_rvalid_d7", {61'd0, rvalid3}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
